// File: rtl/ff_pipe.sv
//------------------------------------------------------------------------------
// ff_pipe : WIDTH x DEPTH elastic register pipeline with valid/ready, bubble
//           collapsing, synchronous flush and occupancy count.
// Optional: `define FF_PIPE_PARITY_EN for per-stage even parity + parity_err.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ff_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count
`ifdef FF_PIPE_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int LAST = DEPTH - 1;

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0]            move;
  logic                        in_fire;
  logic                        out_fire;

`ifdef FF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             perr_q, perr_d;
`endif

  // A stage may advance when it is empty or its successor advances, so
  // empty stages absorb data even while the output is stalled.
  always_comb begin
    logic m;
    move       = '0;
    m          = ~valid_q[LAST] | out_ready;
    move[LAST] = m;
    for (int i = LAST - 1; i >= 0; i--) begin
      m       = ~valid_q[i] | m;
      move[i] = m;
    end
  end

  assign in_ready  = move[0] & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_fire  = out_valid & out_ready;
  assign count     = count_q;

  // Data flops only load when a valid word arrives; flush clears valids only.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
`ifdef FF_PIPE_PARITY_EN
    par_d   = par_q;
`endif
    if (move[0]) begin
      valid_d[0] = in_fire;
      if (in_fire) begin
        data_d[0] = in_data;
`ifdef FF_PIPE_PARITY_EN
        par_d[0]  = ^in_data;
`endif
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (move[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
`ifdef FF_PIPE_PARITY_EN
          par_d[i]  = par_q[i-1];
`endif
        end
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({in_fire, out_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d = '0;
    end
  end

`ifdef FF_PIPE_PARITY_EN
  // Sticky: only reset clears it, flush deliberately leaves it set.
  always_comb begin
    perr_d = perr_q;
    if (out_fire && ((^data_q[LAST]) != par_q[LAST])) begin
      perr_d = 1'b1;
    end
  end

  assign parity_err = perr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
`ifdef FF_PIPE_PARITY_EN
      par_q   <= '0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
`ifdef FF_PIPE_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ff_pipe.sv
//------------------------------------------------------------------------------
// tb_ff_pipe : directed self-checking bench for ff_pipe (WIDTH=8, DEPTH=3).
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ff_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic [1:0] count;
`ifdef FF_PIPE_PARITY_EN
  logic       parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  // One row = inputs for a cycle, in_ready expected before the edge,
  // registered outputs expected after the edge.
  typedef struct packed {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [1:0] cnt;
  } row_t;

  always #5 clk = ~clk;

  ff_pipe #(.WIDTH(8), .DEPTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
`ifdef FF_PIPE_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic drive(input row_t r);
    flush     = r.fl;
    in_valid  = r.iv;
    in_data   = r.id;
    out_ready = r.ordy;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    // Fill two stages with the output stalled, then reset between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'h10;
    @(posedge clk); #1;
    in_data = 8'h20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrun_out_valid got %b want 1", out_valid); end
    n_vec++; if (count !== 2'd2) begin n_err++; $display("FAIL midrun_count got %0d want 2", count); end
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (count !== 2'd0) begin n_err++; $display("FAIL async_rst_count got %0d want 0", count); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL async_rst_out_data got %h want 00", out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (count !== 2'd0) begin n_err++; $display("FAIL post_rst_count got %0d want 0", count); end
  endtask

  task automatic test_streaming();
    row_t rows [7];
    rows = '{
      '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1},
      '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2},
      '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 2'd3},
      '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h22, 2'd3},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 2'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0}
    };
    foreach (rows[k]) begin
      drive(rows[k]); #1;
      n_vec++; if (in_ready !== rows[k].ir) begin n_err++; $display("FAIL stream[%0d] in_ready got %b want %b", k, in_ready, rows[k].ir); end
      @(posedge clk); #1;
      n_vec++; if (out_valid !== rows[k].ov) begin n_err++; $display("FAIL stream[%0d] out_valid got %b want %b", k, out_valid, rows[k].ov); end
      if (rows[k].ov) begin
        n_vec++; if (out_data !== rows[k].od) begin n_err++; $display("FAIL stream[%0d] out_data got %h want %h", k, out_data, rows[k].od); end
      end
      n_vec++; if (count !== rows[k].cnt) begin n_err++; $display("FAIL stream[%0d] count got %0d want %0d", k, count, rows[k].cnt); end
    end
  endtask

  task automatic test_backpressure();
    row_t rows [9];
    rows = '{
      '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1},
      '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2},
      '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA0, 2'd3},
      '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd3},
      '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd3},
      '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd3},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd2},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 2'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0}
    };
    foreach (rows[k]) begin
      drive(rows[k]); #1;
      n_vec++; if (in_ready !== rows[k].ir) begin n_err++; $display("FAIL bp[%0d] in_ready got %b want %b", k, in_ready, rows[k].ir); end
      @(posedge clk); #1;
      n_vec++; if (out_valid !== rows[k].ov) begin n_err++; $display("FAIL bp[%0d] out_valid got %b want %b", k, out_valid, rows[k].ov); end
      if (rows[k].ov) begin
        n_vec++; if (out_data !== rows[k].od) begin n_err++; $display("FAIL bp[%0d] out_data got %h want %h", k, out_data, rows[k].od); end
      end
      n_vec++; if (count !== rows[k].cnt) begin n_err++; $display("FAIL bp[%0d] count got %0d want %0d", k, count, rows[k].cnt); end
    end
  endtask

  task automatic test_bubble();
    row_t rows [9];
    rows = '{
      '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1},
      '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 2'd2},
      '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 2'd3},
      '{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 2'd3},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 2'd2},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 2'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0}
    };
    foreach (rows[k]) begin
      drive(rows[k]); #1;
      n_vec++; if (in_ready !== rows[k].ir) begin n_err++; $display("FAIL bubble[%0d] in_ready got %b want %b", k, in_ready, rows[k].ir); end
      @(posedge clk); #1;
      n_vec++; if (out_valid !== rows[k].ov) begin n_err++; $display("FAIL bubble[%0d] out_valid got %b want %b", k, out_valid, rows[k].ov); end
      if (rows[k].ov) begin
        n_vec++; if (out_data !== rows[k].od) begin n_err++; $display("FAIL bubble[%0d] out_data got %h want %h", k, out_data, rows[k].od); end
      end
      n_vec++; if (count !== rows[k].cnt) begin n_err++; $display("FAIL bubble[%0d] count got %0d want %0d", k, count, rows[k].cnt); end
    end
  endtask

  task automatic test_flush();
    row_t rows [10];
    rows = '{
      '{1'b0, 1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1},
      '{1'b0, 1'b1, 8'h51, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h50, 2'd2},
      '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0},
      '{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h66, 2'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0}
    };
    foreach (rows[k]) begin
      drive(rows[k]); #1;
      n_vec++; if (in_ready !== rows[k].ir) begin n_err++; $display("FAIL flush[%0d] in_ready got %b want %b", k, in_ready, rows[k].ir); end
      @(posedge clk); #1;
      n_vec++; if (out_valid !== rows[k].ov) begin n_err++; $display("FAIL flush[%0d] out_valid got %b want %b", k, out_valid, rows[k].ov); end
      if (rows[k].ov) begin
        n_vec++; if (out_data !== rows[k].od) begin n_err++; $display("FAIL flush[%0d] out_data got %h want %h", k, out_data, rows[k].od); end
      end
      n_vec++; if (count !== rows[k].cnt) begin n_err++; $display("FAIL flush[%0d] count got %0d want %0d", k, count, rows[k].cnt); end
    end
  endtask

`ifdef FF_PIPE_PARITY_EN
  task automatic test_parity();
    flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL parity_pre got %b want 0", parity_err); end
    // 0x0F has even parity 0; corrupt the last-stage parity flop.
    force dut.par_q = 3'b100;
    out_ready = 1'b1;
    @(posedge clk); #1;
    release dut.par_q;
    n_vec++; if (parity_err !== 1'b1) begin n_err++; $display("FAIL parity_set got %b want 1", parity_err); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++; if (parity_err !== 1'b1) begin n_err++; $display("FAIL parity_sticky got %b want 1", parity_err); end
    rst = 1'b1;
    #1;
    n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL parity_rst got %b want 0", parity_err); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout reached without summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
`ifdef FF_PIPE_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
